// File: rtl/ldmac_tag_collect.sv
// LDMAC tag collector: pairs the core's high and low 64-bit tag words into a
// 128-bit tag, optionally compares it against a loaded expected tag, and
// presents the result on a valid/ready interface. The core cannot be stalled,
// so a word arriving while a tag is still held is dropped and flagged.
module ldmac_tag_collect #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        mac_dout,
  input  logic               mac_dout_valid,
  input  logic               mac_done,
  input  logic [127:0]       exp_tag,
  input  logic               exp_tag_load,
  output logic [127:0]       tag,
  output logic               tag_valid,
  input  logic               tag_ready,
  output logic               tag_match,
  output logic               err_seq,
  output logic               err_timeout,
  output logic               err_overrun,
  output logic               busy,
  output logic [CNT_W-1:0]   tag_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, HALF, HOLD} state_t;

  state_t             state;
  logic [63:0]        hi_word;
  logic [127:0]       exp_reg;
  logic               armed;
  logic [TMR_W-1:0]   timer;
  logic               handshake;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign handshake = tag_valid & tag_ready;

  // Collector FSM with all outputs registered; the expected-tag load is
  // applied last so it overrides the armed clear on a coincident handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hi_word     <= '0;
      exp_reg     <= '0;
      armed       <= 1'b0;
      timer       <= '0;
      tag         <= '0;
      tag_valid   <= 1'b0;
      tag_match   <= 1'b0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      busy        <= 1'b0;
      tag_count   <= '0;
    end else begin
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (mac_dout_valid) begin
            if (mac_done) begin
              err_seq <= 1'b1;
            end else begin
              hi_word <= mac_dout;
              timer   <= '0;
              state   <= HALF;
              busy    <= 1'b1;
            end
          end
        end
        HALF: begin
          if (mac_dout_valid) begin
            if (mac_done) begin
              tag       <= {hi_word, mac_dout};
              tag_match <= armed & ({hi_word, mac_dout} == exp_reg);
              tag_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              err_seq <= 1'b1;
              hi_word <= mac_dout;
              timer   <= '0;
            end
          end else if (timer == TMR_MAX) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        HOLD: begin
          if (handshake) begin
            tag_count <= sat_inc(tag_count);
            armed     <= 1'b0;
            tag_valid <= 1'b0;
            tag_match <= 1'b0;
            if (mac_dout_valid && !mac_done) begin
              hi_word <= mac_dout;
              timer   <= '0;
              state   <= HALF;
              busy    <= 1'b1;
            end else begin
              err_seq <= mac_dout_valid;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end else if (mac_dout_valid) begin
            err_overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (exp_tag_load) begin
        exp_reg <= exp_tag;
        armed   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ldmac_tag_collect.sv
// Bench for ldmac_tag_collect: a default-parameter instance checked through a
// tag scoreboard, and a TIMEOUT_CYCLES=8 / CNT_W=2 instance for the timeout
// and counter saturation cases.
module tb_ldmac_tag_collect;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  mac_dout = '0;
  logic         mac_dout_valid = 1'b0;
  logic         mac_done = 1'b0;
  logic [127:0] exp_tag = '0;
  logic         exp_tag_load = 1'b0;
  logic         tag_ready = 1'b0;
  logic         sel_b = 1'b0;
  logic         vld_a, vld_b;

  logic [127:0] tag_a, tag_b;
  logic         tv_a, tm_a, es_a, et_a, eo_a, busy_a;
  logic         tv_b, tm_b, es_b, et_b, eo_b, busy_b;
  logic [15:0]  cnt_a;
  logic [1:0]   cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [127:0] tag;
    logic         match;
  } sb_t;
  sb_t sb[$];

  assign vld_a = mac_dout_valid & ~sel_b;
  assign vld_b = mac_dout_valid & sel_b;

  always #5 clk = ~clk;

  ldmac_tag_collect dut_a (
    .clk(clk), .rst(rst), .mac_dout(mac_dout), .mac_dout_valid(vld_a),
    .mac_done(mac_done), .exp_tag(exp_tag), .exp_tag_load(exp_tag_load),
    .tag(tag_a), .tag_valid(tv_a), .tag_ready(tag_ready), .tag_match(tm_a),
    .err_seq(es_a), .err_timeout(et_a), .err_overrun(eo_a), .busy(busy_a),
    .tag_count(cnt_a)
  );

  ldmac_tag_collect #(.TIMEOUT_CYCLES(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .mac_dout(mac_dout), .mac_dout_valid(vld_b),
    .mac_done(mac_done), .exp_tag(exp_tag), .exp_tag_load(exp_tag_load),
    .tag(tag_b), .tag_valid(tv_b), .tag_ready(tag_ready), .tag_match(tm_b),
    .err_seq(es_b), .err_timeout(et_b), .err_overrun(eo_b), .busy(busy_b),
    .tag_count(cnt_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic d, input logic [63:0] w);
    mac_dout       = w;
    mac_dout_valid = 1'b1;
    mac_done       = d;
    step();
    mac_dout_valid = 1'b0;
    mac_done       = 1'b0;
  endtask

  task automatic load_exp(input logic [127:0] e);
    exp_tag      = e;
    exp_tag_load = 1'b1;
    step();
    exp_tag_load = 1'b0;
  endtask

  // Scoreboard: every handshake on dut_a retires the oldest expected tag.
  always @(negedge clk) begin
    if (!rst && tv_a && tag_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_tag", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_tag", tag_a, e.tag);
        check("sb_match", tm_a, e.match);
      end
    end
  end

  localparam logic [63:0] HI = 64'h0123456789ABCDEF;
  localparam logic [63:0] LO = 64'hFEDCBA9876543210;

  initial begin
    idle(2);
    rst = 1'b0;
    check("rst_tag", tag_a, '0);
    check("rst_valid", tv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_match", tm_a, 0);

    // Armed, matching tag with a 30-cycle gap between words.
    load_exp({HI, LO});
    tag_ready = 1'b1;
    send(0, HI);
    check("t1_busy", busy_a, 1);
    idle(30);
    check("t1_busy_gap", busy_a, 1);
    sb.push_back('{tag: {HI, LO}, match: 1'b1});
    send(1, LO);
    check("t1_valid", tv_a, 1);
    check("t1_match", tm_a, 1);
    idle(1);
    check("t1_valid_drop", tv_a, 0);
    check("t1_cnt", cnt_a, 1);
    check("t1_idle", busy_a, 0);

    // Same words without re-arming: no match.
    send(0, HI);
    idle(30);
    sb.push_back('{tag: {HI, LO}, match: 1'b0});
    send(1, LO);
    check("t2_match", tm_a, 0);
    idle(1);
    check("t2_cnt", cnt_a, 2);

    // Overrun while held, then skid into HALF on the handshake.
    tag_ready = 1'b0;
    send(0, 64'h1111);
    sb.push_back('{tag: {64'h1111, 64'h2222}, match: 1'b0});
    send(1, 64'h2222);
    idle(2);
    check("t3_hold", tv_a, 1);
    send(0, 64'hAA);
    check("t3_overrun", eo_a, 1);
    check("t3_tag_kept", tag_a, {64'h1111, 64'h2222});
    idle(1);
    check("t3_overrun_pulse", eo_a, 0);
    tag_ready = 1'b1;
    send(0, 64'hBB);
    check("t3_skid_busy", busy_a, 1);
    check("t3_skid_valid", tv_a, 0);
    check("t3_skid_ovr", eo_a, 0);
    check("t3_cnt", cnt_a, 3);
    sb.push_back('{tag: {64'hBB, 64'hCC}, match: 1'b0});
    send(1, 64'hCC);
    check("t3_tag", tag_a, {64'hBB, 64'hCC});
    idle(1);
    check("t3_cnt2", cnt_a, 4);

    // Ordering errors in IDLE and HALF.
    send(1, 64'h55);
    check("t4_seq_idle", es_a, 1);
    check("t4_idle_busy", busy_a, 0);
    idle(1);
    check("t4_seq_pulse", es_a, 0);
    send(0, 64'h10);
    check("t4_no_seq", es_a, 0);
    send(0, 64'h20);
    check("t4_seq_half", es_a, 1);
    check("t4_half_busy", busy_a, 1);
    sb.push_back('{tag: {64'h20, 64'h30}, match: 1'b0});
    send(1, 64'h30);
    idle(1);
    check("t4_cnt", cnt_a, 5);

    // Handshake coinciding with a done word: sequence error, back to IDLE.
    tag_ready = 1'b0;
    send(0, 64'h61);
    sb.push_back('{tag: {64'h61, 64'h62}, match: 1'b0});
    send(1, 64'h62);
    tag_ready = 1'b1;
    send(1, 64'h63);
    check("t5_seq", es_a, 1);
    check("t5_busy", busy_a, 0);
    check("t5_valid", tv_a, 0);
    check("t5_cnt", cnt_a, 6);

    // Load in HOLD keeps the latched match; load with handshake keeps armed.
    tag_ready = 1'b0;
    send(0, 64'hA1);
    sb.push_back('{tag: {64'hA1, 64'hB1}, match: 1'b0});
    send(1, 64'hB1);
    load_exp({64'hA1, 64'hB1});
    check("t6_match_latched", tm_a, 0);
    tag_ready = 1'b1;
    load_exp({64'hC1, 64'hD1});
    send(0, 64'hC1);
    sb.push_back('{tag: {64'hC1, 64'hD1}, match: 1'b1});
    send(1, 64'hD1);
    check("t6_match_armed", tm_a, 1);
    idle(1);
    check("t6_cnt", cnt_a, 8);

    // Timeout on the TIMEOUT_CYCLES=8 instance.
    sel_b = 1'b1;
    send(0, 64'h77);
    idle(8);
    check("t7_no_to_yet", et_b, 0);
    check("t7_busy", busy_b, 1);
    idle(1);
    check("t7_timeout", et_b, 1);
    check("t7_idle", busy_b, 0);
    idle(1);
    check("t7_to_pulse", et_b, 0);
    send(0, 64'h78);
    idle(8);
    send(1, 64'h79);
    check("t7_late_valid", tv_b, 1);
    check("t7_late_no_to", et_b, 0);
    check("t7_late_tag", tag_b, {64'h78, 64'h79});
    idle(1);
    check("t7_cnt", cnt_b, 1);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 4; i++) begin
      send(0, 64'(i));
      send(1, 64'(i + 100));
      idle(1);
      if (i == 1) check("t8_cnt3", cnt_b, 3);
    end
    check("t8_sat", cnt_b, 3);
    sel_b = 1'b0;

    // Reset while holding a tag, and while half-collected.
    tag_ready = 1'b0;
    send(0, 64'h1);
    send(1, 64'h2);
    check("t9_hold", tv_a, 1);
    rst = 1'b1;
    step();
    check("t9_rst_valid", tv_a, 0);
    check("t9_rst_tag", tag_a, '0);
    check("t9_rst_busy", busy_a, 0);
    check("t9_rst_cnt", cnt_a, 0);
    check("t9_rst_errs", {es_a, et_a, eo_a}, 0);
    check("t9_rst_cnt_b", cnt_b, 0);
    rst = 1'b0;
    send(0, 64'h5);
    check("t9_half", busy_a, 1);
    rst = 1'b1;
    step();
    check("t9_rst_half_busy", busy_a, 0);
    check("t9_rst_half_errs", {es_a, et_a, eo_a}, 0);
    rst = 1'b0;
    idle(2);
    check("t9_after_rst", {tv_a, busy_a, es_a, et_a, eo_a}, 0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
